// File: rtl/mrc_pkg.sv
// Shared types and helpers for the memory result checker.
package mrc_pkg;

  // Checker phases: wait for start, watch the core, compare memories, hold results.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SCAN = 2'd2,
    DONE = 2'd3
  } mrc_state_e;

  // Default parameter set of the checker.
  localparam int unsigned MRC_DATA_W_DEF = 32;
  localparam int unsigned MRC_ADDR_W_DEF = 5;

  // Width of one mismatch log entry {idx, expected, got}.
  function automatic int unsigned log_entry_w(input int unsigned addr_w,
                                              input int unsigned data_w);
    return addr_w + 2 * data_w;
  endfunction

  // Log entry width for the default parameter set.
  localparam int unsigned MRC_LOG_ENTRY_W = MRC_ADDR_W_DEF + 2 * MRC_DATA_W_DEF;

endpackage

// File: rtl/mrc_err_fifo.sv
// Synchronous FIFO (pointer + count) holding mismatch log entries.
module mrc_err_fifo #(
  parameter int unsigned WIDTH = 69,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push_c;
  logic             do_pop_c;

  // Wrap-around pointer increment, valid for any depth.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_pop_c  = pop_i && !empty_o;
  assign do_push_c = push_i && (!full_o || do_pop_c);

  // Pointer and occupancy bookkeeping; flush empties the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push_c) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop_c)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push_c, do_pop_c})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_result_checker.sv
// End-of-program checker: watches the core PC, then compares data memory
// against the answer memory word by word and reports the verdict.
// Optional mismatch log FIFO enabled by defining MRC_ERR_LOG_EN.
module mem_result_checker
  import mrc_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned TIMEOUT   = 30,
  parameter int unsigned LOG_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [PC_W-1:0]              pc,
  input  logic [PC_W-3:0]              eof_idx,
  output logic [ADDR_W-1:0]            scan_addr,
  input  logic [DATA_W-1:0]            dmem_rdata,
  input  logic [DATA_W-1:0]            ans_rdata,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic                         timeout,
  output logic [$clog2(DEPTH+1)-1:0]   err_cnt,
  output logic [ADDR_W-1:0]            first_err,
  output logic [$clog2(TIMEOUT+1)-1:0] cycle_cnt,
  output logic                         log_valid,
  input  logic                         log_ready,
  output logic [ADDR_W+2*DATA_W-1:0]   log_data,
  output logic                         log_ovf
);

  localparam int unsigned ERR_W = $clog2(DEPTH + 1);
  localparam int unsigned CYC_W = $clog2(TIMEOUT + 1);
  localparam int unsigned IDX_W = PC_W - 2;
  localparam int unsigned LOG_W = log_entry_w(ADDR_W, DATA_W);

  mrc_state_e        state_q;
  logic [IDX_W-1:0]  eof_q;
  logic [ADDR_W-1:0] idx_q;
  logic [ERR_W-1:0]  err_q;
  logic [ADDR_W-1:0] first_q;
  logic [CYC_W-1:0]  cyc_q;
  logic              to_q;

  logic [IDX_W-1:0]  pc_idx_c;
  logic [1:0]        pc_byte_unused;
  logic              eof_hit_c;
  logic              tmo_hit_c;
  logic              mism_c;
  logic              last_idx_c;
  logic              start_ok_c;

  // PC is a byte address; only the word index matters.
  assign pc_idx_c       = pc[PC_W-1:2];
  assign pc_byte_unused = pc[1:0];

  assign eof_hit_c  = (pc_idx_c >= eof_q);
  assign tmo_hit_c  = (cyc_q == CYC_W'(TIMEOUT - 1));
  assign mism_c     = (dmem_rdata != ans_rdata);
  assign last_idx_c = (idx_q == ADDR_W'(DEPTH - 1));
  assign start_ok_c = start && ((state_q == IDLE) || (state_q == DONE));

  // Phase sequencing, RUN cycle counter and SCAN comparator bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      eof_q   <= '0;
      idx_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      cyc_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            eof_q   <= eof_idx;
            idx_q   <= '0;
            err_q   <= '0;
            first_q <= '0;
            cyc_q   <= '0;
            to_q    <= 1'b0;
          end
        end
        RUN: begin
          cyc_q <= cyc_q + CYC_W'(1);
          // End of program takes priority over a simultaneous timeout.
          if (eof_hit_c) begin
            state_q <= SCAN;
          end else if (tmo_hit_c) begin
            state_q <= DONE;
            to_q    <= 1'b1;
          end
        end
        SCAN: begin
          if (mism_c) begin
            err_q <= err_q + ERR_W'(1);
            if (err_q == '0) first_q <= idx_q;
          end
          if (last_idx_c) begin
            state_q <= DONE;
            idx_q   <= '0;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign scan_addr = idx_q;
  assign busy      = (state_q == RUN) || (state_q == SCAN);
  assign done      = (state_q == DONE);
  assign timeout   = to_q;
  assign pass      = (state_q == DONE) && !to_q && (err_q == '0);
  assign err_cnt   = err_q;
  assign first_err = first_q;
  assign cycle_cnt = cyc_q;

`ifdef MRC_ERR_LOG_EN
  logic             flush_c;
  logic             push_c;
  logic             pop_c;
  logic             full_c;
  logic             empty_c;
  logic [LOG_W-1:0] head_c;
  logic             ovf_q;

  assign flush_c = start_ok_c;
  assign push_c  = (state_q == SCAN) && mism_c;
  assign pop_c   = log_ready && !empty_c;

  mrc_err_fifo #(
    .WIDTH (LOG_W),
    .DEPTH (LOG_DEPTH)
  ) u_err_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_c),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .wdata_i ({idx_q, ans_rdata, dmem_rdata}),
    .rdata_o (head_c),
    .full_o  (full_c),
    .empty_o (empty_c)
  );

  // Sticky flag for a mismatch that found no room in the log.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (flush_c) begin
      ovf_q <= 1'b0;
    end else if (push_c && full_c && !pop_c) begin
      ovf_q <= 1'b1;
    end
  end

  assign log_valid = !empty_c;
  assign log_data  = head_c;
  assign log_ovf   = ovf_q;
`else
  localparam int unsigned LOG_DEPTH_UNUSED = LOG_DEPTH;
  logic log_ready_unused;
  logic start_ok_unused;

  assign log_ready_unused = log_ready;
  assign start_ok_unused  = start_ok_c;
  assign log_valid        = 1'b0;
  assign log_data         = {LOG_W{1'b0}};
  assign log_ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_mem_result_checker.sv
// Self-checking bench for mem_result_checker with a queue-based reference model.
module tb_mem_result_checker;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned DEPTH     = 32;
  localparam int unsigned ADDR_W    = 5;
  localparam int unsigned PC_W      = 32;
  localparam int unsigned TIMEOUT   = 30;
  localparam int unsigned LOG_DEPTH = 4;
  localparam int unsigned IDX_W     = PC_W - 2;
  localparam int unsigned ERR_W     = $clog2(DEPTH + 1);
  localparam int unsigned CYC_W     = $clog2(TIMEOUT + 1);
  localparam int unsigned LOG_W     = ADDR_W + 2 * DATA_W;
`ifdef MRC_ERR_LOG_EN
  localparam bit LOG_EN = 1'b1;
`else
  localparam bit LOG_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [PC_W-1:0]   pc;
  logic [IDX_W-1:0]  eof_idx;
  logic [ADDR_W-1:0] scan_addr;
  logic [DATA_W-1:0] dmem_rdata;
  logic [DATA_W-1:0] ans_rdata;
  logic              busy;
  logic              done;
  logic              pass;
  logic              timeout;
  logic [ERR_W-1:0]  err_cnt;
  logic [ADDR_W-1:0] first_err;
  logic [CYC_W-1:0]  cycle_cnt;
  logic              log_valid;
  logic              log_ready;
  logic [LOG_W-1:0]  log_data;
  logic              log_ovf;

  logic [DATA_W-1:0] dmem_mem [DEPTH];
  logic [DATA_W-1:0] ans_mem  [DEPTH];

  int vectors;
  int miscompares;

  // Reference log contents and overflow flag.
  logic [LOG_W-1:0] logq [$];
  bit               ovf_m;

  mem_result_checker #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W),
    .PC_W      (PC_W),
    .TIMEOUT   (TIMEOUT),
    .LOG_DEPTH (LOG_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pc         (pc),
    .eof_idx    (eof_idx),
    .scan_addr  (scan_addr),
    .dmem_rdata (dmem_rdata),
    .ans_rdata  (ans_rdata),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .timeout    (timeout),
    .err_cnt    (err_cnt),
    .first_err  (first_err),
    .cycle_cnt  (cycle_cnt),
    .log_valid  (log_valid),
    .log_ready  (log_ready),
    .log_data   (log_data),
    .log_ovf    (log_ovf)
  );

  always #5 clk = ~clk;

  // Asynchronous-read memories addressed by the checker.
  assign dmem_rdata = dmem_mem[scan_addr];
  assign ans_rdata  = ans_mem[scan_addr];

  // Full program: random PC trace, memories with mismatches at mask bits,
  // expectations derived from the trace and the mask.
  task automatic run_case(input string name, input logic [IDX_W-1:0] eof,
                          input int eof_cyc, input logic [DEPTH-1:0] mask,
                          input int ready_mode, input bit drain);
    logic [IDX_W-1:0]  pcs [TIMEOUT];
    logic [LOG_W-1:0]  exp_ld;
    int k, lat, exp_err, exp_first, exp_cyc, exp_sa, j;
    bit exp_to, exp_pass, exp_lv, rdy, popped, full;

    for (int i = 0; i < int'(TIMEOUT); i++) begin
      if (eof_cyc >= 0 && i == eof_cyc)
        pcs[i] = eof + IDX_W'($urandom_range(0, 3));
      else if (eof_cyc < 0 || i < eof_cyc)
        pcs[i] = IDX_W'($urandom_range(0, 32'(eof) - 1));
      else
        pcs[i] = IDX_W'($urandom);
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      ans_mem[i]  = $urandom;
      dmem_mem[i] = mask[i] ? (ans_mem[i] ^ ($urandom | 32'd1)) : ans_mem[i];
    end

    k = -1;
    for (int i = 0; i < int'(TIMEOUT); i++)
      if (k < 0 && pcs[i] >= eof) k = i;
    if (k >= 0) begin
      lat = k + 1 + int'(DEPTH);
      exp_cyc = k + 1;
      exp_to = 1'b0;
      exp_err = $countones(mask);
      exp_first = 0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) if (mask[i]) exp_first = i;
    end else begin
      lat = int'(TIMEOUT);
      exp_cyc = int'(TIMEOUT);
      exp_to = 1'b1;
      exp_err = 0;
      exp_first = 0;
    end
    exp_pass = !exp_to && (exp_err == 0);

    start = 1'b1;
    eof_idx = eof;
    log_ready = 1'b0;
    logq.delete();
    ovf_m = 1'b0;
    @(negedge clk);

    for (int n = 0; n <= lat; n++) begin
      exp_sa = (k >= 0 && n > k && n < lat) ? (n - k - 1) : 0;
      vectors++;
      if ({busy, done, scan_addr} !== {n < lat, n == lat, ADDR_W'(exp_sa)}) begin
        miscompares++;
        $display("FAIL %s_phase n=%0d: busy/done/scan_addr got %b/%b/%0d expected %b/%b/%0d",
                 name, n, busy, done, scan_addr, n < lat, n == lat, exp_sa);
      end
      exp_lv = logq.size() > 0;
      exp_ld = '0;
      if (exp_lv) exp_ld = logq[0];
      vectors++;
      if ({log_valid, log_data, log_ovf} !== {exp_lv, exp_ld, ovf_m}) begin
        miscompares++;
        $display("FAIL %s_log n=%0d: valid/data/ovf got %b/%h/%b expected %b/%h/%b",
                 name, n, log_valid, log_data, log_ovf, exp_lv, exp_ld, ovf_m);
      end
      if (n == lat) break;

      // Stray starts during RUN/SCAN (with a different eof) must be ignored.
      start = (n == 1) || (k >= 0 && n == k + 4);
      eof_idx = start ? '0 : eof;
      pc = (n < int'(TIMEOUT)) ? {pcs[n], 2'($urandom)} : $urandom;

      if (k >= 0 && n > k) begin
        j = n - k - 1;
        rdy = (ready_mode == 1) ? 1'($urandom) : (ready_mode == 2) ? (j >= 4) : 1'b0;
        log_ready = rdy;
        popped = rdy && (logq.size() > 0);
        full = (logq.size() == int'(LOG_DEPTH));
        if (popped) void'(logq.pop_front());
        if (LOG_EN && mask[j]) begin
          if (!full || popped) logq.push_back({ADDR_W'(j), ans_mem[j], dmem_mem[j]});
          else ovf_m = 1'b1;
        end
      end else begin
        log_ready = 1'b0;
      end
      @(negedge clk);
    end

    start = 1'b0;
    log_ready = 1'b0;
    for (int h = 0; h < 3; h++) begin
      vectors++;
      if ({done, pass, timeout, err_cnt, first_err, cycle_cnt} !==
          {1'b1, exp_pass, exp_to, ERR_W'(exp_err), ADDR_W'(exp_first), CYC_W'(exp_cyc)}) begin
        miscompares++;
        $display("FAIL %s_result h=%0d: done/pass/to/err/first/cyc got %b/%b/%b/%0d/%0d/%0d expected 1/%b/%b/%0d/%0d/%0d",
                 name, h, done, pass, timeout, err_cnt, first_err, cycle_cnt,
                 exp_pass, exp_to, exp_err, exp_first, exp_cyc);
      end
      pc = $urandom;
      @(negedge clk);
    end

    if (drain) begin
      for (int d = 0; d <= int'(LOG_DEPTH); d++) begin
        exp_lv = logq.size() > 0;
        exp_ld = '0;
        if (exp_lv) exp_ld = logq[0];
        vectors++;
        if ({log_valid, log_data} !== {exp_lv, exp_ld}) begin
          miscompares++;
          $display("FAIL %s_drain d=%0d: valid/data got %b/%h expected %b/%h",
                   name, d, log_valid, log_data, exp_lv, exp_ld);
        end
        log_ready = 1'b1;
        if (exp_lv) void'(logq.pop_front());
        @(negedge clk);
      end
      log_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    pc = '0;
    eof_idx = '0;
    log_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      dmem_mem[i] = '0;
      ans_mem[i]  = '0;
    end
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, done, pass, timeout, err_cnt, first_err, cycle_cnt, scan_addr,
         log_valid, log_data, log_ovf} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: busy=%b done=%b pass=%b to=%b err=%0d scan=%0d lv=%b expected all 0",
               busy, done, pass, timeout, err_cnt, scan_addr, log_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done, pass, timeout, scan_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_idle: busy/done/pass/to/scan got %b/%b/%b/%b/%0d expected 0",
               busy, done, pass, timeout, scan_addr);
    end
  endtask

  task automatic test_match();
    run_case("match", IDX_W'(8), 10, '0, 0, 1'b1);
  endtask

  task automatic test_mismatch();
    run_case("mismatch", IDX_W'(8), 10, (32'd1 << 3) | (32'd1 << 17), 0, 1'b1);
  endtask

  task automatic test_timeout();
    run_case("timeout", IDX_W'(500), -1, 32'hFFFF_0000, 1, 1'b1);
  endtask

  task automatic test_tie();
    run_case("tie", IDX_W'(20), int'(TIMEOUT) - 1, 32'h0000_0101, 0, 1'b1);
  endtask

  task automatic test_log_overflow();
    run_case("log_ovf", IDX_W'(12), 3, 32'h4010_1224, 0, 1'b1);
    run_case("log_full_pop", IDX_W'(12), 2, 32'h0000_003F, 2, 1'b1);
  endtask

  task automatic test_start_clears();
    run_case("dirty_log", IDX_W'(40), 5, 32'h8000_0F01, 0, 1'b0);
    run_case("after_dirty", IDX_W'(40), 6, '0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_scan();
    start = 1'b1;
    eof_idx = IDX_W'(5);
    pc = {IDX_W'(9), 2'b00};
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 60 && scan_addr != ADDR_W'(10); n++) @(negedge clk);
    vectors++;
    if (scan_addr !== ADDR_W'(10) || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_scan_reach: scan_addr/busy got %0d/%b expected 10/1", scan_addr, busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busy, done, pass, timeout, err_cnt, first_err, cycle_cnt, scan_addr,
         log_valid, log_data, log_ovf} !== '0) begin
      miscompares++;
      $display("FAIL mid_scan_reset: busy=%b done=%b err=%0d cyc=%0d scan=%0d lv=%b expected all 0",
               busy, done, err_cnt, cycle_cnt, scan_addr, log_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done, scan_addr} !== '0) begin
      miscompares++;
      $display("FAIL mid_scan_idle: busy/done/scan got %b/%b/%0d expected 0/0/0", busy, done, scan_addr);
    end
    run_case("rerun", IDX_W'(8), 4, 32'h0010_0400, 1, 1'b1);
  endtask

  task automatic test_random();
    int c;
    for (int r = 0; r < 10; r++) begin
      c = int'($urandom_range(0, TIMEOUT));
      if (c == int'(TIMEOUT)) c = -1;
      run_case("random", IDX_W'($urandom_range(1, 64)), c, $urandom & $urandom,
               int'($urandom_range(0, 1)), 1'b1);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_match();
    test_mismatch();
    test_timeout();
    test_tie();
    test_log_overflow();
    test_start_clears();
    test_reset_mid_scan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
